bcd_conv_seq: RTL and testbench
===============================

# bcd_conv_seq

Sequential, parametrised binary-to-BCD converter for the calculator display path. It accepts one signed or unsigned binary operand over a valid/ready handshake and runs shift-add-3 (double dabble), one bit per clock. It returns a sign nibble plus DIGITS BCD digits, with an overflow flag and optional leading-zero blanking. It replaces the combinational converter between the ALU result register and the seven-segment digit driver. It handles the most-negative input correctly, which the previous generation did not.

## Interface
- BIN_W, 21: input operand width, 2..32.
- DIGITS, 7: number of BCD digits produced, 1..10.
- SIGNED, 1: 1 means `bin` is two's complement; 0 means unsigned.
- BLANK_LZ, 0: 1 means leading zero digits are output as blank code 4'hF. The units digit is never blanked.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand present.
- in_ready  out  1  converter can accept an operand.
- bin  in  BIN_W  operand; sampled only on an in_valid&&in_ready edge.
- out_valid  out  1  result held stable on bcdnum/ovf.
- out_ready  in  1  consumer takes the result.
- bcdnum  out  4*(DIGITS+1)  [top nibble] sign code, then DIGITS digits, most significant first; units digit in [3:0].
- ovf  out  1  magnitude needs more than DIGITS digits.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - SHIFT: converting.
  - DONE: out_valid=1.
- IDLE→SHIFT on in_valid&&in_ready. On that edge:
  - capture neg = SIGNED & bin[BIN_W-1];
  - capture the magnitude as a BIN_W-bit unsigned value. This is -bin if neg, else bin.
  - Most-negative case: -2^(BIN_W-1) yields magnitude 2^(BIN_W-1), which is exact in BIN_W bits. It must convert correctly.
  - clear the digit accumulator, the bit counter and the sticky overflow.
- SHIFT, each cycle:
  - every digit ≥5 gets +3;
  - then the digit accumulator and magnitude register shift left together by 1;
  - the bit leaving the top digit ORs into sticky ovf.
  - Exactly BIN_W cycles, counted by a $clog2(BIN_W+1)-bit counter. The last shift moves SHIFT→DONE.
- DONE→IDLE on out_ready. in_valid is ignored outside IDLE.
- Output formatting, registered on the SHIFT→DONE edge:
  - sign nibble: 4'hB if neg, else 4'hF.
  - ovf=1: all digits forced to 4'h9, blanking not applied.
  - BLANK_LZ=1, ovf=0: each zero digit above the most significant nonzero digit becomes 4'hF. A value of 0 shows blank digits with units 4'h0.
  - A result of magnitude 0 is never marked negative.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=1, out_valid=0, ovf=0
  - bcdnum = sign 4'hF with all digits 4'h0, regardless of BLANK_LZ.
- Latency: accept edge at cycle 0; out_valid rises after edge BIN_W+1. That is BIN_W+1 cycles from accept to valid.
- Throughput: one conversion per BIN_W+2 cycles when out_ready is held high. There is no overlap: in_ready=0 in SHIFT and DONE.
- bcdnum and ovf are stable while out_valid=1. They keep the last result after the handshake until the next SHIFT→DONE edge.
- out_valid drops on the edge where out_valid&&out_ready. in_ready rises on that same edge.
- rst_n asserted mid-SHIFT or in DONE: immediate return to reset values. The in-flight operand is discarded with no partial output.
- out_ready high in IDLE or SHIFT has no effect.

## Structure
- Package bcd_pkg holds:
  - localparams BCD_SIGN_NEG=4'hB, BCD_SIGN_POS=4'hF, BCD_BLANK=4'hF;
  - the state enum typedef {IDLE, SHIFT, DONE}.
- One sub-module is natural: bcd_add3, a combinational per-digit "≥5 then +3" cell, instantiated DIGITS times via generate.
- Leading-zero blanking is a generate loop at the output register, with a running "all higher digits zero" chain.

## Test plan
- Defaults, bin=0 → after 22 cycles out_valid=1, bcdnum=32'hF000_0000, ovf=0.
- Defaults, bin=1048575 → bcdnum=32'hF104_8575; bin=-1048576 → bcdnum=32'hB104_8576, ovf=0.
- DIGITS=3, BIN_W=12, SIGNED=0, bin=1000 → ovf=1, bcdnum=16'hF999. Then bin=999 → ovf=0, bcdnum=16'hF999.
- BLANK_LZ=1, bin=-42 → bcdnum=32'hBFFF_FF42. Then bin=0 → 32'hFFFF_FFF0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid while toggling in_valid/bin.
  - Required: in_ready=0 throughout;
  - bcdnum unchanged;
  - first out_ready=1 edge clears out_valid and raises in_ready;
  - the next operand converts correctly.
- Drop rst_n at SHIFT cycle 7.
  - Required: outputs go to reset values immediately.
  - A fresh bin=123 after release yields 32'hF000_0123 with no residue.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam logic [3:0] BCD_SIGN_NEG = 4'hB;
  localparam logic [3:0] BCD_SIGN_POS = 4'hF;
  localparam logic [3:0] BCD_BLANK    = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit cell: a BCD digit of 5 or more gets +3 ahead of the shift.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout_c
);

  always_comb begin
    dout_c = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/bcd_conv_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with sign nibble, sticky overflow
// and optional leading-zero blanking, behind valid/ready handshakes on both sides.
module bcd_conv_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W    = 21,
  parameter int unsigned DIGITS   = 7,
  parameter int unsigned SIGNED   = 1,
  parameter int unsigned BLANK_LZ = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIN_W-1:0]        bin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*(DIGITS+1)-1:0] bcdnum,
  output logic                    ovf
);

  localparam int unsigned ACC_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   mag;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_adj_c;
  logic [ACC_W-1:0]   acc_shift_c;
  logic [ACC_W-1:0]   digits_fmt_c;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic               sticky;
  logic               accept_c;
  logic               last_c;
  logic               neg_in_c;
  logic               ovf_fin_c;
  logic [DIGITS:1]    hz_c;

  assign accept_c    = in_valid && in_ready;
  assign last_c      = (cnt == CNT_W'(BIN_W - 1));
  assign neg_in_c    = (SIGNED != 0) && bin[BIN_W-1];
  assign acc_shift_c = {acc_adj_c[ACC_W-2:0], mag[BIN_W-1]};
  assign ovf_fin_c   = sticky | acc_adj_c[ACC_W-1];
  assign hz_c[DIGITS] = 1'b1;

  // Per-digit add-3 correction and output formatting; hz_c tracks "all higher digits zero".
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dig
    logic [3:0] dig_c;

    bcd_add3 u_add3 (
      .din    (acc[4*g +: 4]),
      .dout_c (acc_adj_c[4*g +: 4])
    );

    assign dig_c = acc_shift_c[4*g +: 4];

    if (g == 0) begin : g_units
      assign digits_fmt_c[3:0] = ovf_fin_c ? 4'h9 : dig_c;
    end else begin : g_upper
      if (g < int'(DIGITS) - 1) begin : g_chain
        assign hz_c[g] = hz_c[g+1] & (dig_c == 4'h0);
      end else begin : g_top
        assign hz_c[g] = (DIGITS > 1) ? (dig_c == 4'h0) : 1'b1;
      end
      assign digits_fmt_c[4*g +: 4] = ovf_fin_c ? 4'h9 :
                                      ((BLANK_LZ != 0) && hz_c[g]) ? BCD_BLANK : dig_c;
    end
  end

  // State and handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c)  state_nxt = SHIFT;
      SHIFT:   if (last_c)    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, shift loop, result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag    <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      sticky <= 1'b0;
      bcdnum <= {BCD_SIGN_POS, {ACC_W{1'b0}}};
      ovf    <= 1'b0;
    end else if (accept_c) begin
      neg    <= neg_in_c;
      mag    <= neg_in_c ? BIN_W'(~bin + 1'b1) : bin;
      acc    <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
    end else if (state == SHIFT) begin
      acc    <= acc_shift_c;
      mag    <= {mag[BIN_W-2:0], 1'b0};
      cnt    <= cnt + CNT_W'(1);
      sticky <= ovf_fin_c;
      if (last_c) begin
        // neg implies a nonzero magnitude, so zero never carries the minus code
        bcdnum <= {(neg ? BCD_SIGN_NEG : BCD_SIGN_POS), digits_fmt_c};
        ovf    <= ovf_fin_c;
      end
    end
  end

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Directed bench for bcd_conv_seq across three parameter sets, with a scoreboard
// queue filled from a decimal reference model.
module tb_bcd_conv_seq;

  typedef struct {
    int          idx;
    logic [31:0] bcd;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic iv0, iv1, iv2, or0, or1, or2;
  logic [20:0] bin0, bin2;
  logic [11:0] bin1;
  logic ir0, ir1, ir2, ov0, ov1, ov2, ovf0, ovf1, ovf2;
  logic [31:0] bcd0, bcd2;
  logic [15:0] bcd1;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  logic [31:0] last_bcd;

  always #5 clk = ~clk;

  bcd_conv_seq u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .bin(bin0),
    .out_valid(ov0), .out_ready(or0), .bcdnum(bcd0), .ovf(ovf0)
  );

  bcd_conv_seq #(.BIN_W(12), .DIGITS(3), .SIGNED(0), .BLANK_LZ(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .bin(bin1),
    .out_valid(ov1), .out_ready(or1), .bcdnum(bcd1), .ovf(ovf1)
  );

  bcd_conv_seq #(.BIN_W(21), .DIGITS(7), .SIGNED(1), .BLANK_LZ(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .bin(bin2),
    .out_valid(ov2), .out_ready(or2), .bcdnum(bcd2), .ovf(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int get_bw(input int idx);
    return (idx == 1) ? 12 : 21;
  endfunction

  function automatic logic [31:0] get_bcd(input int idx);
    case (idx)
      0:       return bcd0;
      1:       return {16'h0, bcd1};
      default: return bcd2;
    endcase
  endfunction

  function automatic logic get_ov(input int idx);
    case (idx)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic get_ir(input int idx);
    case (idx)
      0:       return ir0;
      1:       return ir1;
      default: return ir2;
    endcase
  endfunction

  function automatic logic get_ovf(input int idx);
    case (idx)
      0:       return ovf0;
      1:       return ovf1;
      default: return ovf2;
    endcase
  endfunction

  // Reference: decimal arithmetic on the magnitude, then sign/overflow/blanking rules
  function automatic exp_t model(input int idx, input logic [31:0] b);
    exp_t        e;
    int          bw, dg;
    bit          sg, bl, neg, lead;
    longint      v, mag, lim;
    logic [3:0]  d [10];
    bw  = get_bw(idx);
    dg  = (idx == 1) ? 3 : 7;
    sg  = (idx != 1);
    bl  = (idx == 2);
    v   = longint'(b) & ((longint'(1) << bw) - 1);
    neg = sg && b[bw-1];
    mag = neg ? (longint'(1) << bw) - v : v;
    lim = 1;
    for (int i = 0; i < dg; i++) lim = lim * 10;
    e.ovf = (mag >= lim);
    for (int i = 0; i < 10; i++) begin
      d[i] = e.ovf ? 4'h9 : 4'(mag % 10);
      mag  = mag / 10;
    end
    if (bl && !e.ovf) begin
      lead = 1'b1;
      for (int i = dg - 1; i >= 1; i--) begin
        if (lead && d[i] == 4'h0) d[i] = 4'hF;
        else lead = 1'b0;
      end
    end
    e.bcd = '0;
    for (int i = 0; i < dg; i++) e.bcd[4*i +: 4] = d[i];
    e.bcd[4*dg +: 4] = neg ? 4'hB : 4'hF;
    e.idx = idx;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int idx, input logic v, input logic [31:0] b);
    case (idx)
      0: begin iv0 = v; bin0 = b[20:0]; end
      1: begin iv1 = v; bin1 = b[11:0]; end
      default: begin iv2 = v; bin2 = b[20:0]; end
    endcase
  endtask

  task automatic set_or(input int idx, input logic v);
    case (idx)
      0:       or0 = v;
      1:       or1 = v;
      default: or2 = v;
    endcase
  endtask

  task automatic release_out(input int idx);
    set_or(idx, 1'b1);
    tick();
    check($sformatf("ov_drop%0d", idx), 32'(get_ov(idx)), 32'd0);
    check($sformatf("ir_rise%0d", idx), 32'(get_ir(idx)), 32'd1);
    set_or(idx, 1'b0);
  endtask

  task automatic convert(input int idx, input logic [31:0] b, input bit hold);
    exp_t e;
    int   n;
    check($sformatf("ir_pre%0d", idx), 32'(get_ir(idx)), 32'd1);
    set_in(idx, 1'b1, b);
    sb.push_back(model(idx, b));
    tick();
    n = 1;
    set_in(idx, 1'b0, 32'($urandom));
    check($sformatf("ir_busy%0d", idx), 32'(get_ir(idx)), 32'd0);
    while (!get_ov(idx) && n < 100) begin
      tick();
      n++;
    end
    check($sformatf("latency%0d", idx), 32'(n), 32'(get_bw(idx) + 1));
    e = sb.pop_front();
    check($sformatf("bcd%0d_%h", idx, b), get_bcd(e.idx), e.bcd);
    check($sformatf("ovf%0d_%h", idx, b), 32'(get_ovf(e.idx)), 32'(e.ovf));
    last_bcd = e.bcd;
    if (!hold) release_out(idx);
  endtask

  initial begin
    rst_n = 1'b0;
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    or0 = 1'b0; or1 = 1'b0; or2 = 1'b0;
    bin0 = '0; bin1 = '0; bin2 = '0;
    last_bcd = '0;
    tick();
    tick();
    check("rst_bcd0", bcd0, 32'hF000_0000);
    check("rst_bcd1", {16'h0, bcd1}, 32'h0000_F000);
    check("rst_bcd2", bcd2, 32'hF000_0000);
    check("rst_flags", {ir0, ir1, ir2, ov0, ov1, ov2, ovf0, ovf1, ovf2}, 32'b111_000_000);
    rst_n = 1'b1;
    tick();

    // Default parameter set, including extremes and the most-negative operand
    convert(0, 32'd0, 1'b0);
    convert(0, 32'd1048575, 1'b0);
    convert(0, 32'(-1048576), 1'b0);
    convert(0, 32'(-1), 1'b0);
    convert(0, 32'd123456, 1'b0);
    repeat (3) convert(0, 32'($urandom), 1'b0);

    // Three-digit unsigned: overflow saturation and the boundary just below it
    convert(1, 32'd1000, 1'b0);
    convert(1, 32'd999, 1'b0);
    convert(1, 32'd4095, 1'b0);
    convert(1, 32'd0, 1'b0);
    convert(1, 32'd7, 1'b0);

    // Leading-zero blanking
    convert(2, 32'(-42), 1'b0);
    convert(2, 32'd0, 1'b0);
    convert(2, 32'd5, 1'b0);
    convert(2, 32'd1000000, 1'b0);
    convert(2, 32'(-1048576), 1'b0);

    // Backpressure: result held, input ignored while out_ready stays low
    convert(0, 32'd777777, 1'b1);
    for (int i = 0; i < 10; i++) begin
      set_in(0, 1'($urandom), 32'($urandom));
      tick();
      check($sformatf("bp_ir_%0d", i), 32'(ir0), 32'd0);
      check($sformatf("bp_ov_%0d", i), 32'(ov0), 32'd1);
      check($sformatf("bp_bcd_%0d", i), bcd0, last_bcd);
    end
    set_in(0, 1'b0, 32'd0);
    release_out(0);
    check("bp_hold_after", bcd0, last_bcd);
    convert(0, 32'(-5), 1'b0);

    // Reset in the middle of a conversion
    set_in(0, 1'b1, 32'(-12345));
    tick();
    set_in(0, 1'b0, 32'd0);
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_bcd", bcd0, 32'hF000_0000);
    check("mid_rst_flags", {29'h0, ir0, ov0, ovf0}, 32'b100);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ov", 32'(ov0), 32'd0);
    convert(0, 32'd123, 1'b0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
